// File: rtl/spmv_result_packer_if.sv
// Output stream of the SpMV result packer: one packed write-back word per beat,
// with a byte mask and an end-of-vector marker.
interface spmv_result_packer_if #(
    parameter int OUT_W = 512
);
    logic                 tvalid;
    logic                 tready;
    logic [OUT_W-1:0]     tdata;
    logic [OUT_W/8-1:0]   tkeep;
    logic                 tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/spmv_result_packer.sv
// Packs one result vector from the selected precision lane (double/single/half)
// into OUT_W-bit write-back words, masking and flagging the final partial word.
module spmv_result_packer #(
    parameter int OUT_W = 512,
    parameter int LEN_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          Ctrl_sig,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    input  logic                in_double_valid,
    output logic                in_double_ready,
    input  logic [63:0]         in_double_data,
    input  logic                in_single_valid,
    output logic                in_single_ready,
    input  logic [31:0]         in_single_data,
    input  logic                in_half_valid,
    output logic                in_half_ready,
    input  logic [15:0]         in_half_data,
    spmv_result_packer_if.master m_axis
);

    localparam int KEEP_W    = OUT_W / 8;
    localparam int LANES_D   = OUT_W / 64;
    localparam int LANES_S   = OUT_W / 32;
    localparam int LANES_H   = OUT_W / 16;
    localparam int IDX_W     = (LANES_H > 1) ? $clog2(LANES_H) : 1;
    localparam int OFF_W     = $clog2(OUT_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_HALF   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_DOUBLE = 2'd2
    } mode_t;

    // Ctrl_sig encoding 3 is deliberately folded onto double precision.
    function automatic mode_t decode_mode(input logic [1:0] ctrl);
        mode_t m;
        case (ctrl)
            2'd0:    m = MODE_HALF;
            2'd1:    m = MODE_SINGLE;
            default: m = MODE_DOUBLE;
        endcase
        return m;
    endfunction

    function automatic logic [KEEP_W-1:0] keep_mask(input mode_t mode, input logic [IDX_W:0] filled);
        logic [KEEP_W-1:0] mask;
        logic [1:0]        sh;
        mask = '0;
        case (mode)
            MODE_HALF:   sh = 2'd1;
            MODE_SINGLE: sh = 2'd2;
            default:     sh = 2'd3;
        endcase
        for (int b = 0; b < KEEP_W; b++) begin
            mask[b] = ((b >> sh) < int'(filled));
        end
        return mask;
    endfunction

    state_t              state_r;
    mode_t               mode_r;
    logic [LEN_W-1:0]    elem_cnt_r;
    logic [IDX_W-1:0]    lane_idx_r;
    logic [OUT_W-1:0]    acc_r;
    logic                busy_r;
    logic                done_r;
    logic                tvalid_r;
    logic [OUT_W-1:0]    tdata_r;
    logic [KEEP_W-1:0]   tkeep_r;
    logic                tlast_r;

    logic                sel_valid_s;
    logic [OUT_W-1:0]    elem_s;
    logic [IDX_W-1:0]    lanes_m1_s;
    logic [OFF_W-1:0]    bit_off_s;
    logic                last_elem_s;
    logic                word_full_s;
    logic                complete_s;
    logic                out_free_s;
    logic                lane_ready_s;
    logic                accept_s;
    logic [OUT_W-1:0]    merged_s;
    logic [IDX_W:0]      filled_s;

    // Lane mux: select the active input lane, its element width and bit offset.
    always_comb begin
        sel_valid_s = 1'b0;
        elem_s      = '0;
        lanes_m1_s  = '0;
        bit_off_s   = '0;
        case (mode_r)
            MODE_HALF: begin
                sel_valid_s = in_half_valid;
                elem_s      = OUT_W'(in_half_data);
                lanes_m1_s  = IDX_W'(LANES_H - 1);
                bit_off_s   = OFF_W'(lane_idx_r) << 3'd4;
            end
            MODE_SINGLE: begin
                sel_valid_s = in_single_valid;
                elem_s      = OUT_W'(in_single_data);
                lanes_m1_s  = IDX_W'(LANES_S - 1);
                bit_off_s   = OFF_W'(lane_idx_r) << 3'd5;
            end
            default: begin
                sel_valid_s = in_double_valid;
                elem_s      = OUT_W'(in_double_data);
                lanes_m1_s  = IDX_W'(LANES_D - 1);
                bit_off_s   = OFF_W'(lane_idx_r) << 3'd6;
            end
        endcase
    end

    // A word-completing element may only enter when the output register can take the word.
    assign last_elem_s  = (elem_cnt_r == LEN_W'(1));
    assign word_full_s  = (lane_idx_r == lanes_m1_s);
    assign complete_s   = last_elem_s || word_full_s;
    assign out_free_s   = !tvalid_r || m_axis.tready;
    assign lane_ready_s = (state_r == ST_FILL) && (!complete_s || out_free_s);
    assign accept_s     = lane_ready_s && sel_valid_s;
    assign merged_s     = acc_r | (elem_s << bit_off_s);
    assign filled_s     = {1'b0, lane_idx_r} + (IDX_W+1)'(1);

    assign in_double_ready = lane_ready_s && (mode_r == MODE_DOUBLE);
    assign in_single_ready = lane_ready_s && (mode_r == MODE_SINGLE);
    assign in_half_ready   = lane_ready_s && (mode_r == MODE_HALF);

    assign busy          = busy_r;
    assign done          = done_r;
    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tdata  = tdata_r;
    assign m_axis.tkeep  = tkeep_r;
    assign m_axis.tlast  = tlast_r;

    // Control FSM, accumulation register, counters and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_HALF;
            elem_cnt_r <= '0;
            lane_idx_r <= '0;
            acc_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tvalid_r   <= 1'b0;
            tdata_r    <= '0;
            tkeep_r    <= '0;
            tlast_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (tvalid_r && m_axis.tready) begin
                tvalid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            mode_r     <= decode_mode(Ctrl_sig);
                            elem_cnt_r <= len;
                            lane_idx_r <= '0;
                            acc_r      <= '0;
                            busy_r     <= 1'b1;
                            state_r    <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        if (elem_cnt_r != '0) begin
                            elem_cnt_r <= elem_cnt_r - LEN_W'(1);
                        end
                        if (complete_s) begin
                            // Unfilled lanes are already zero because acc_r is cleared per word.
                            tvalid_r   <= 1'b1;
                            tdata_r    <= merged_s;
                            tkeep_r    <= keep_mask(mode_r, filled_s);
                            tlast_r    <= last_elem_s;
                            acc_r      <= '0;
                            lane_idx_r <= '0;
                            if (last_elem_s) begin
                                state_r <= ST_DRAIN;
                            end
                        end else begin
                            acc_r      <= merged_s;
                            lane_idx_r <= lane_idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tvalid_r && m_axis.tready) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_result_packer.sv
// Scoreboard bench for spmv_result_packer: stimulus pushes expected words,
// an independent monitor pops and compares on every output handshake.
module tb_spmv_result_packer;

    localparam int OUT_W  = 512;
    localparam int LEN_W  = 32;
    localparam int KEEP_W = OUT_W / 8;

    typedef struct packed {
        logic [OUT_W-1:0]  data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } word_t;

    logic              clk;
    logic              rst;
    logic [1:0]        Ctrl_sig;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              in_double_valid;
    logic              in_double_ready;
    logic [63:0]       in_double_data;
    logic              in_single_valid;
    logic              in_single_ready;
    logic [31:0]       in_single_data;
    logic              in_half_valid;
    logic              in_half_ready;
    logic [15:0]       in_half_data;

    spmv_result_packer_if #(.OUT_W(OUT_W)) m_axis ();

    spmv_result_packer #(.OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .Ctrl_sig        (Ctrl_sig),
        .start           (start),
        .len             (len),
        .busy            (busy),
        .done            (done),
        .in_double_valid (in_double_valid),
        .in_double_ready (in_double_ready),
        .in_double_data  (in_double_data),
        .in_single_valid (in_single_valid),
        .in_single_ready (in_single_ready),
        .in_single_data  (in_single_data),
        .in_half_valid   (in_half_valid),
        .in_half_ready   (in_half_ready),
        .in_half_data    (in_half_data),
        .m_axis          (m_axis.master)
    );

    word_t exp_q[$];
    word_t last_word;
    int    total = 0;
    int    bad = 0;
    int    words_seen = 0;
    logic  rand_rdy = 1'b0;
    logic  done_due = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected words for a vector whose element k is base+k, element width w bits.
    task automatic push_vec(input int w, input int n, input logic [63:0] base);
        word_t cur;
        int lanes;
        logic [63:0] v;
        lanes = OUT_W / w;
        cur = '0;
        for (int k = 0; k < n; k++) begin
            int lane;
            lane = k % lanes;
            v = base + 64'(k);
            case (w)
                64: begin cur.data[lane*64 +: 64] = v;       cur.keep[lane*8 +: 8] = '1; end
                32: begin cur.data[lane*32 +: 32] = v[31:0]; cur.keep[lane*4 +: 4] = '1; end
                default: begin cur.data[lane*16 +: 16] = v[15:0]; cur.keep[lane*2 +: 2] = '1; end
            endcase
            if (lane == lanes - 1 || k == n - 1) begin
                cur.last = (k == n - 1);
                exp_q.push_back(cur);
                cur = '0;
            end
        end
    endtask

    // Monitor: scoreboard pops on handshakes and done-timing check every cycle.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            chk("done_timing", done, done_due);
            if (!rst && m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", m_axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", m_axis.tdata, e.data);
                    chk("word_keep", m_axis.tkeep, e.keep);
                    chk("word_last", m_axis.tlast, e.last);
                    last_word.data = m_axis.tdata;
                    last_word.keep = m_axis.tkeep;
                    last_word.last = m_axis.tlast;
                    words_seen++;
                end
            end
            done_due = !rst && ((m_axis.tvalid && m_axis.tready && m_axis.tlast) || (start && len == '0));
        end
    end

    // Downstream ready: constant 1 or random 50% when rand_rdy is set.
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic start_vec(input logic [1:0] ctrl, input int l);
        start    = 1'b1;
        Ctrl_sig = ctrl;
        len      = LEN_W'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Feed elements first..first+cnt-1 of an n-element vector on lane m (2 double, 1 single, 0 half).
    task automatic send(input int m, input int n, input int first, input int cnt,
                        input logic [63:0] base, input int toggle_at);
        int   lanes;
        int   guard;
        logic hs, rdy, oth, comp, exp_rdy;
        logic [63:0] v;
        lanes = (m == 1) ? 16 : ((m == 0) ? 32 : 8);
        for (int k = first; k < first + cnt; k++) begin
            v = base + 64'(k);
            case (m)
                1:       begin in_single_valid = 1'b1; in_single_data = v[31:0]; end
                0:       begin in_half_valid   = 1'b1; in_half_data   = v[15:0]; end
                default: begin in_double_valid = 1'b1; in_double_data = v;       end
            endcase
            if (k == toggle_at) Ctrl_sig = 2'd0;
            comp  = ((k % lanes) == lanes - 1) || (k == n - 1);
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 200) begin
                @(negedge clk);
                case (m)
                    1:       begin rdy = in_single_ready; oth = in_double_ready | in_half_ready;   end
                    0:       begin rdy = in_half_ready;   oth = in_double_ready | in_single_ready; end
                    default: begin rdy = in_double_ready; oth = in_single_ready | in_half_ready;   end
                endcase
                exp_rdy = !comp || !m_axis.tvalid || m_axis.tready;
                chk("lane_ready", rdy, exp_rdy);
                chk("other_ready", oth, 1'b0);
                chk("busy_fill", busy, 1'b1);
                hs = rdy;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!hs) begin
                total++;
                bad++;
                $display("FAIL elem_timeout: got no ready expected ready for element %0d", k);
                return;
            end else if (comp) begin
                chk("word_latency", m_axis.tvalid, 1'b1);
            end
        end
        case (m)
            1:       in_single_valid = 1'b0;
            0:       in_half_valid   = 1'b0;
            default: in_double_valid = 1'b0;
        endcase
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 2000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [OUT_W-1:0] d;
        int ws;
        rst = 1'b1; start = 1'b0; Ctrl_sig = 2'd2; len = '0;
        in_double_valid = 1'b0; in_double_data = '0;
        in_single_valid = 1'b0; in_single_data = '0;
        in_half_valid   = 1'b0; in_half_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tvalid", m_axis.tvalid, 1'b0);
        chk("rst_tdata", m_axis.tdata, '0);
        chk("rst_readies", {in_double_ready, in_single_ready, in_half_ready}, 3'b000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Double, len 8: one full word, lane k = k.
        push_vec(64, 8, 64'h0);
        start_vec(2'd2, 8);
        send(2, 8, 0, 8, 64'h0, -1);
        wait_drain();
        chk("dbl_done_pulse", done, 1'b1);
        d = last_word.data;
        chk("dbl_lane7", d[511:448], 64'd7);
        chk("dbl_keep", last_word.keep, {KEEP_W{1'b1}});
        chk("dbl_last", last_word.last, 1'b1);

        // Half, len 33: full word then one-lane tail; started in the done cycle.
        push_vec(16, 33, 64'h1000);
        start_vec(2'd0, 33);
        send(0, 33, 0, 33, 64'h1000, -1);
        wait_drain();
        d = last_word.data;
        chk("half_tail_lane0", d[15:0], 16'h1020);
        chk("half_tail_upper", d >> 16, '0);
        chk("half_tail_keep", last_word.keep, 64'h3);

        // Single, len 20, random downstream stalls.
        ws = words_seen;
        rand_rdy = 1'b1;
        push_vec(32, 20, 64'hA000_0000);
        start_vec(2'd1, 20);
        send(1, 20, 0, 20, 64'hA000_0000, -1);
        wait_drain();
        rand_rdy = 1'b0;
        chk("single_words", words_seen - ws, 2);
        chk("single_tail_keep", last_word.keep, 64'hFFFF);
        @(posedge clk);
        #1;

        // Zero-length vector: done only.
        start_vec(2'd1, 0);
        chk("len0_done", done, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("len0_busy", busy, 1'b0);
            @(posedge clk);
            #1;
        end

        // Double with Ctrl_sig toggled mid-run and other lanes valid.
        in_single_valid = 1'b1;
        in_half_valid   = 1'b1;
        push_vec(64, 16, 64'h100);
        start_vec(2'd2, 16);
        send(2, 16, 0, 16, 64'h100, 3);
        wait_drain();
        in_single_valid = 1'b0;
        in_half_valid   = 1'b0;
        Ctrl_sig = 2'd2;
        @(posedge clk);
        #1;

        // Reset after 5 of 16 doubles: abort, then a clean vector.
        ws = words_seen;
        start_vec(2'd2, 16);
        send(2, 16, 0, 5, 64'h500, -1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_readies", {in_double_ready, in_single_ready, in_half_ready}, 3'b000);
        chk("abort_tvalid", m_axis.tvalid, 1'b0);
        chk("abort_tdata", m_axis.tdata, '0);
        chk("abort_tkeep", m_axis.tkeep, '0);
        chk("abort_tlast", m_axis.tlast, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_word", words_seen - ws, 0);
        push_vec(64, 8, 64'h800);
        start_vec(2'd2, 8);
        send(2, 8, 0, 8, 64'h800, -1);
        wait_drain();
        d = last_word.data;
        chk("post_rst_lane0", d[63:0], 64'h800);
        chk("post_rst_words", words_seen - ws, 1);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
